// File: rtl/axi4_burst_addr_gen_if.sv
// Descriptor-in / beat-out bundle for axi4_burst_addr_gen.
// slave  : view taken by the address generator (accepts descriptors, emits beats)
// master : view taken by the front-end / memory side driving descriptors and consuming beats
interface axi4_burst_addr_gen_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 1024
);
  localparam int unsigned WIDX_W = $clog2(MEM_DEPTH);

  // descriptor channel
  logic                  desc_valid;
  logic                  desc_ready;
  logic [ADDR_WIDTH-1:0] desc_addr;
  logic [7:0]            desc_len;
  logic [2:0]            desc_size;
  logic [1:0]            desc_burst;

  // beat channel
  logic                  beat_valid;
  logic                  beat_ready;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [WIDX_W-1:0]     beat_widx;
  logic [7:0]            beat_idx;
  logic                  beat_last;
  logic [1:0]            beat_resp;

  modport slave (
    input  desc_valid, desc_addr, desc_len, desc_size, desc_burst, beat_ready,
    output desc_ready, beat_valid, beat_addr, beat_widx, beat_idx, beat_last, beat_resp
  );

  modport master (
    output desc_valid, desc_addr, desc_len, desc_size, desc_burst, beat_ready,
    input  desc_ready, beat_valid, beat_addr, beat_widx, beat_idx, beat_last, beat_resp
  );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Per-beat AXI4 address/response generator.
// Accepts one burst descriptor (addr, len, size, burst) and emits len+1 beat
// records carrying byte address, memory word index, beat number, last flag and
// response. FIXED/INCR/WRAP address math, protocol checks and a per-beat
// memory range check are applied; erroneous bursts still emit every beat.
// Optional feature macro: AXI_4K_CHECK_EN -- when defined, an INCR burst that
// would cross a 4 KB page is flagged SLVERR for all of its beats.
module axi4_burst_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input logic                  ACLK,
  input logic                  ARESETn,
  axi4_burst_addr_gen_if.slave bus
);

  localparam int unsigned NB       = DATA_WIDTH / 8;
  localparam int unsigned LOG2_NB  = $clog2(NB);
  localparam int unsigned WIDX_W   = $clog2(MEM_DEPTH);

  localparam logic [2:0]            MAX_SIZE  = 3'(LOG2_NB);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // control state
  logic [0:0]            state_q;
  logic                  desc_ready_q;
  logic                  beat_valid_q;

  // latched descriptor
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic [ADDR_WIDTH-1:0] bytes_q;
  logic [ADDR_WIDTH-1:0] wrap_lower_q;
  logic [ADDR_WIDTH-1:0] wrap_bound_q;
  logic                  err_q;

  // current beat record
  logic [ADDR_WIDTH-1:0] beat_addr_q;
  logic [WIDX_W-1:0]     beat_widx_q;
  logic [7:0]            beat_idx_q;
  logic                  beat_last_q;
  logic [1:0]            beat_resp_q;

  // descriptor decode
  logic [ADDR_WIDTH-1:0] d_bytes;
  logic [ADDR_WIDTH-1:0] d_mask;
  logic [ADDR_WIDTH-1:0] d_total;
  logic [ADDR_WIDTH-1:0] d_lower;
  logic [ADDR_WIDTH-1:0] d_bound;
  logic                  d_len_ok;
  logic                  d_err;
`ifdef AXI_4K_CHECK_EN
  logic [ADDR_WIDTH:0]   d_end;
`endif

  // next-beat datapath
  logic [ADDR_WIDTH-1:0] nxt_inc;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [7:0]            nxt_idx;

  logic                  accept;
  logic                  fire;

  assign accept = bus.desc_valid & desc_ready_q;
  assign fire   = beat_valid_q & bus.beat_ready;

  function automatic logic [1:0] resp_for(input logic [ADDR_WIDTH-1:0] a, input logic burst_err);
    if (burst_err || ({1'b0, a >> LOG2_NB} >= DEPTH_LIM))
      return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [WIDX_W-1:0] widx_for(input logic [ADDR_WIDTH-1:0] a);
    return WIDX_W'(a >> LOG2_NB);
  endfunction

  // Decode the offered descriptor: beat size, wrap window and whole-burst error.
  always_comb begin
    d_bytes  = ONE_A << bus.desc_size;
    d_mask   = d_bytes - ONE_A;
    d_total  = d_bytes * (ADDR_WIDTH'(bus.desc_len) + ONE_A);
    d_lower  = bus.desc_addr & ~(d_total - ONE_A);
    d_bound  = d_lower + d_total;
    d_len_ok = (bus.desc_len == 8'd1) || (bus.desc_len == 8'd3) ||
               (bus.desc_len == 8'd7) || (bus.desc_len == 8'd15);
    d_err    = 1'b0;
    if (bus.desc_burst == BURST_RSVD)
      d_err = 1'b1;
    if (bus.desc_size > MAX_SIZE)
      d_err = 1'b1;
    if ((bus.desc_burst == BURST_WRAP) && (!d_len_ok || ((bus.desc_addr & d_mask) != '0)))
      d_err = 1'b1;
`ifdef AXI_4K_CHECK_EN
    // last byte computed one bit wider so a wrap past the top of the address
    // space also registers as a page change
    d_end = {1'b0, bus.desc_addr & ~d_mask} + {1'b0, d_total} - {1'b0, ONE_A};
    if ((bus.desc_burst == BURST_INCR) &&
        (d_end[ADDR_WIDTH:12] != {1'b0, bus.desc_addr[ADDR_WIDTH-1:12]}))
      d_err = 1'b1;
`endif
  end

  // Address of the following beat, derived from the current one.
  always_comb begin
    nxt_inc  = beat_addr_q + bytes_q;
    nxt_idx  = beat_idx_q + 8'd1;
    nxt_addr = beat_addr_q;
    case (burst_q)
      // realigning each step makes an unaligned first beat land on the
      // aligned base + n*bytes sequence from beat 1 onward
      BURST_INCR: nxt_addr = (beat_addr_q & ~(bytes_q - ONE_A)) + bytes_q;
      BURST_WRAP: nxt_addr = (nxt_inc == wrap_bound_q) ? wrap_lower_q : nxt_inc;
      default:    nxt_addr = beat_addr_q;
    endcase
  end

  // Handshake FSM: IDLE accepts a descriptor, BURST emits beats until the last is consumed.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= ST_IDLE;
      desc_ready_q <= 1'b0;
      beat_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q      <= ST_BURST;
            desc_ready_q <= 1'b0;
            beat_valid_q <= 1'b1;
          end else begin
            desc_ready_q <= 1'b1;
          end
        end
        ST_BURST: begin
          if (fire && beat_last_q) begin
            state_q      <= ST_IDLE;
            desc_ready_q <= 1'b1;
            beat_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          desc_ready_q <= 1'b0;
          beat_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Capture the descriptor parameters needed for the rest of the burst.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      len_q        <= '0;
      burst_q      <= BURST_FIXED;
      bytes_q      <= '0;
      wrap_lower_q <= '0;
      wrap_bound_q <= '0;
      err_q        <= 1'b0;
    end else if (accept) begin
      len_q        <= bus.desc_len;
      burst_q      <= bus.desc_burst;
      bytes_q      <= d_bytes;
      wrap_lower_q <= d_lower;
      wrap_bound_q <= d_bound;
      err_q        <= d_err;
    end
  end

  // Beat record: load beat 0 on acceptance, advance on each non-final handshake, else hold.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      beat_addr_q <= '0;
      beat_widx_q <= '0;
      beat_idx_q  <= '0;
      beat_last_q <= 1'b0;
      beat_resp_q <= RESP_OKAY;
    end else if (accept) begin
      beat_addr_q <= bus.desc_addr;
      beat_widx_q <= widx_for(bus.desc_addr);
      beat_idx_q  <= '0;
      beat_last_q <= (bus.desc_len == 8'd0);
      beat_resp_q <= resp_for(bus.desc_addr, d_err);
    end else if (fire && !beat_last_q) begin
      beat_addr_q <= nxt_addr;
      beat_widx_q <= widx_for(nxt_addr);
      beat_idx_q  <= nxt_idx;
      beat_last_q <= (nxt_idx == len_q);
      beat_resp_q <= resp_for(nxt_addr, err_q);
    end
  end

  assign bus.desc_ready = desc_ready_q;
  assign bus.beat_valid = beat_valid_q;
  assign bus.beat_addr  = beat_addr_q;
  assign bus.beat_widx  = beat_widx_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.beat_last  = beat_last_q;
  assign bus.beat_resp  = beat_resp_q;

  // descriptor and beat channels are never open in the same cycle
  a_ready_valid_excl: assert property (@(posedge ACLK) disable iff (!ARESETn)
    !(desc_ready_q && beat_valid_q));

  // beat numbering never runs past the burst length
  a_idx_bound: assert property (@(posedge ACLK) disable iff (!ARESETn)
    beat_valid_q |-> (beat_idx_q <= len_q));

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Scoreboard bench for axi4_burst_addr_gen (ADDR_WIDTH=16, DATA_WIDTH=32, MEM_DEPTH=1024).
// Expected beats are computed from the descriptor when it is driven and popped
// as the DUT hands beats over.
module tb_axi4_burst_addr_gen;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;

  logic ACLK = 1'b0;
  logic ARESETn;

  always #5 ACLK = ~ACLK;

  axi4_burst_addr_gen_if #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) bus ();

  axi4_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [9:0]  widx;
    logic [7:0]  idx;
    logic        last;
    logic [1:0]  resp;
    bit          chk_addr;
  } beat_t;

  beat_t sb[$];

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int          ready_mode  = 0;

  bit          hold_pend = 1'b0;
  logic [36:0] hold_val;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected beat list straight from the burst rules.
  task automatic push_expected(input logic [15:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
    int unsigned bytes, total, lower, bound, cur, a, base;
    bit          err;
    beat_t       b;
    bytes = 32'd1 << size;
    total = bytes * (int'(len) + 1);
    err   = (burst == 2'b11) || (size > 3'd2) ||
            ((burst == 2'b10) && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((addr % bytes) != 0)));
    base  = addr & ~(bytes - 1);
`ifdef AXI_4K_CHECK_EN
    if ((burst == 2'b01) && (((base + total - 1) >> 12) != (int'(addr) >> 12)))
      err = 1'b1;
`endif
    lower = (addr & ~(total - 1)) & 32'hFFFF;
    bound = (lower + total) & 32'hFFFF;
    a     = addr;
    for (int n = 0; n <= int'(len); n++) begin
      case (burst)
        2'b01:   cur = (n == 0) ? int'(addr) : ((base + n * bytes) & 32'hFFFF);
        2'b10:   cur = a;
        default: cur = addr;
      endcase
      b.addr     = cur[15:0];
      b.widx     = cur[11:2];
      b.idx      = n[7:0];
      b.last     = (n == int'(len));
      b.resp     = (err || ((cur >> 2) >= DEPTH)) ? 2'b10 : 2'b00;
      b.chk_addr = (burst != 2'b11);
      sb.push_back(b);
      if (burst == 2'b10) begin
        a = (a + bytes) & 32'hFFFF;
        if (a == bound) a = lower;
      end
    end
  endtask

  // Downstream ready pattern, changed just after each rising edge.
  always @(posedge ACLK) begin
    #1;
    case (ready_mode)
      0:       bus.beat_ready = 1'b1;
      1:       bus.beat_ready = ~bus.beat_ready;
      default: bus.beat_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Beat monitor: stability while stalled, scoreboard compare on each handshake.
  always @(negedge ACLK) begin
    beat_t e;
    if (!ARESETn) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        check_val("hold", {bus.beat_addr, bus.beat_widx, bus.beat_idx, bus.beat_last, bus.beat_resp}, hold_val);
      hold_pend = bus.beat_valid && !bus.beat_ready;
      hold_val  = {bus.beat_addr, bus.beat_widx, bus.beat_idx, bus.beat_last, bus.beat_resp};
      if (bus.beat_valid && bus.beat_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.chk_addr) check_val("beat_addr", bus.beat_addr, e.addr);
          check_val("beat_idx",  bus.beat_idx,  e.idx);
          check_val("beat_last", bus.beat_last, e.last);
          check_val("beat_resp", bus.beat_resp, e.resp);
          if (e.resp == 2'b00) check_val("beat_widx", bus.beat_widx, e.widx);
        end
      end
    end
  end

  task automatic send_desc(input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
    int w;
    ready_mode = mode;
    w = 0;
    while (!bus.desc_ready && w < 200) begin
      @(posedge ACLK); #1;
      w++;
    end
    check_val("desc_ready_wait", bus.desc_ready, 1);
    bus.desc_addr  = addr;
    bus.desc_len   = len;
    bus.desc_size  = size;
    bus.desc_burst = burst;
    bus.desc_valid = 1'b1;
    push_expected(addr, len, size, burst);
    @(posedge ACLK); #1;
    bus.desc_valid = 1'b0;
    check_val("busy_ready_low", bus.desc_ready, 0);
    check_val("first_beat_valid", bus.beat_valid, 1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    do begin
      @(posedge ACLK); #1;
      w++;
    end while (sb.size() != 0 && w < 2000);
    check_val("drain", sb.size(), 0);
    check_val("idle_valid", bus.beat_valid, 0);
    check_val("idle_ready", bus.desc_ready, 1);
  endtask

  task automatic run_burst(input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
    send_desc(addr, len, size, burst, mode);
    drain();
  endtask

  initial begin
    int          w;
    logic [1:0]  rb;
    logic [7:0]  rl;
    ARESETn        = 1'b0;
    bus.desc_valid = 1'b0;
    bus.desc_addr  = '0;
    bus.desc_len   = '0;
    bus.desc_size  = '0;
    bus.desc_burst = '0;
    bus.beat_ready = 1'b0;

    #12;
    check_val("rst_desc_ready", bus.desc_ready, 0);
    check_val("rst_beat_valid", bus.beat_valid, 0);
    check_val("rst_beat_addr",  bus.beat_addr,  0);
    check_val("rst_beat_widx",  bus.beat_widx,  0);
    check_val("rst_beat_idx",   bus.beat_idx,   0);
    check_val("rst_beat_last",  bus.beat_last,  0);
    check_val("rst_beat_resp",  bus.beat_resp,  0);

    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    check_val("rel_ready_pre", bus.desc_ready, 0);
    @(posedge ACLK); #1;
    check_val("rel_ready_post", bus.desc_ready, 1);

    run_burst(16'h0010, 8'd3, 3'd2, 2'b01, 0);   // INCR 0x10..0x1C
    run_burst(16'h0038, 8'd3, 3'd2, 2'b10, 0);   // WRAP 0x38,0x3C,0x30,0x34
    run_burst(16'h0040, 8'd2, 3'd2, 2'b10, 0);   // WRAP illegal len
    run_burst(16'h0050, 8'd2, 3'd2, 2'b11, 0);   // reserved burst type
    run_burst(16'h0060, 8'd1, 3'd3, 2'b01, 0);   // size wider than bus
    run_burst(16'h0032, 8'd3, 3'd2, 2'b10, 0);   // WRAP unaligned
    run_burst(16'h0100, 8'd4, 3'd2, 2'b00, 1);   // FIXED with stalls
    run_burst(16'h0FFC, 8'd1, 3'd2, 2'b01, 0);   // 4 KB / range edge
    run_burst(16'h0FF8, 8'd1, 3'd2, 2'b01, 0);   // just inside page and range
    run_burst(16'h0020, 8'd0, 3'd2, 2'b01, 0);   // single beat
    run_burst(16'h0013, 8'd3, 3'd2, 2'b01, 1);   // INCR unaligned start
    run_burst(16'h0200, 8'd15, 3'd0, 2'b10, 1);  // WRAP bytes, 16 beats
    run_burst(16'h0300, 8'd7, 3'd1, 2'b10, 2);   // WRAP halfwords

    // reset in the middle of a burst
    send_desc(16'h0400, 8'd7, 3'd2, 2'b01, 0);
    w = 0;
    while (sb.size() > 6 && w < 100) begin
      @(posedge ACLK); #1;
      w++;
    end
    check_val("mid_two_beats", sb.size(), 6);
    ARESETn = 1'b0;
    #1;
    check_val("mid_rst_valid", bus.beat_valid, 0);
    check_val("mid_rst_ready", bus.desc_ready, 0);
    check_val("mid_rst_idx",   bus.beat_idx,   0);
    check_val("mid_rst_addr",  bus.beat_addr,  0);
    check_val("mid_rst_last",  bus.beat_last,  0);
    sb.delete();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    run_burst(16'h0500, 8'd3, 3'd2, 2'b01, 0);

    // random mix with random back-pressure
    for (int k = 0; k < 24; k++) begin
      rb = 2'($urandom_range(0, 3));
      rl = 8'($urandom_range(0, 15));
      if (rb == 2'b10 && $urandom_range(0, 3) != 0) rl = 8'((1 << $urandom_range(1, 4)) - 1);
      run_burst(16'($urandom_range(0, 16'h1FFF)), rl, 3'($urandom_range(0, 3)), rb, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
